// File: rtl/quad_pkg.sv
// quad_pkg: phase encoding, direction codes, FSM states and phase-step helper
// shared by the quadrature generator and decoder.
`default_nettype none

package quad_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Right walks 00->01->11->10->00; left walks the same ring backwards.
  function automatic logic [1:0] next_phase(input logic [1:0] phase, input logic dir);
    logic [1:0] nxt;
    case (phase)
      PH_00:   nxt = (dir == DIR_RIGHT) ? PH_01 : PH_10;
      PH_01:   nxt = (dir == DIR_RIGHT) ? PH_11 : PH_00;
      PH_11:   nxt = (dir == DIR_RIGHT) ? PH_10 : PH_01;
      default: nxt = (dir == DIR_RIGHT) ? PH_00 : PH_11;
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/quad_step_generator_dwell_timer.sv
// quad_dwell_timer: loadable down-counter with zero flag, holds the per-phase dwell.
`default_nettype none

module quad_dwell_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/quad_step_generator.sv
// quad_step_generator: emits Gray-coded A/B steps on command, with a fixed dwell
// per phase and a signed wrap-around position counter.
`default_nettype none

module quad_step_generator
  import quad_pkg::*;
#(
  parameter int PHASE_CYCLES = 4,
  parameter int STEP_W       = 8,
  parameter int POS_W        = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [STEP_W-1:0]       cmd_steps,
  input  logic                    abort,
  output logic                    quad_a,
  output logic                    quad_b,
  output logic                    busy,
  output logic                    done,
  output logic signed [POS_W-1:0] position
);

  localparam int DW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [DW-1:0]           DWELL_MAX = DW'(PHASE_CYCLES - 1);
  localparam logic [STEP_W-1:0]       STEP_ONE  = 1;
  localparam logic signed [POS_W-1:0] POS_ONE   = 1;

  state_t                    state_q;
  logic                      dir_q;
  logic [STEP_W-1:0]         steps_q;
  logic [1:0]                phase_q;
  logic signed [POS_W-1:0]   pos_q;
  logic                      ready_q;
  logic                      busy_q;
  logic                      done_q;

  logic                      dwell_zero;
  logic                      dwell_load;
  logic [DW-1:0]             dwell_load_val;
  logic                      dwell_dec;
  logic                      accept;
  logic                      advance;

  assign accept  = (state_q == IDLE) && cmd_valid;
  assign advance = (state_q == RUN) && !abort && dwell_zero && (steps_q != '0);

  // Acceptance clears the dwell so the first edge follows one cycle later.
  assign dwell_load     = accept || advance;
  assign dwell_load_val = accept ? '0 : DWELL_MAX;
  assign dwell_dec      = (state_q == RUN) && !abort && !dwell_zero;

  quad_dwell_timer #(
    .W (DW)
  ) u_dwell (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (dwell_load),
    .load_val_i (dwell_load_val),
    .dec_i      (dwell_dec),
    .zero_o     (dwell_zero)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      dir_q   <= DIR_RIGHT;
      steps_q <= '0;
      phase_q <= PH_00;
      pos_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            dir_q   <= cmd_dir;
            steps_q <= cmd_steps;
            state_q <= RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (dwell_zero) begin
            if (steps_q != '0) begin
              phase_q <= next_phase(phase_q, dir_q);
              steps_q <= steps_q - STEP_ONE;
              pos_q   <= (dir_q == DIR_RIGHT) ? pos_q + POS_ONE : pos_q - POS_ONE;
            end else begin
              state_q <= IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign quad_a    = phase_q[1];
  assign quad_b    = phase_q[0];
  assign position  = pos_q;

endmodule

`default_nettype wire

// File: tb/tb_quad_step_generator.sv
// tb_quad_step_generator: randomized commands checked cycle by cycle against a
// schedule-based model (position arithmetic, phase = Gray ring indexed by position).
`default_nettype none

module tb_quad_step_generator;

  localparam int P  = 4;
  localparam int SW = 8;
  localparam int PW = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic          cmd_valid = 1'b0, cmd_dir = 1'b0, abort = 1'b0;
  logic [SW-1:0] cmd_steps = '0;
  logic          cmd_ready, quad_a, quad_b, busy, done;
  logic [PW-1:0] position;

  logic          f_valid = 1'b0, f_dir = 1'b0, f_abort = 1'b0;
  logic [SW-1:0] f_steps = '0;
  logic          f_ready, f_a, f_b, f_busy, f_done;
  logic [PW-1:0] f_position;

  quad_step_generator #(.PHASE_CYCLES(P), .STEP_W(SW), .POS_W(PW)) u_dut (
    .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .abort(abort),
    .quad_a(quad_a), .quad_b(quad_b), .busy(busy), .done(done), .position(position)
  );

  quad_step_generator #(.PHASE_CYCLES(1), .STEP_W(SW), .POS_W(PW)) u_dut_fast (
    .CLK(CLK), .RST(RST), .cmd_valid(f_valid), .cmd_ready(f_ready),
    .cmd_dir(f_dir), .cmd_steps(f_steps), .abort(f_abort),
    .quad_a(f_a), .quad_b(f_b), .busy(f_busy), .done(f_done), .position(f_position)
  );

  int checks   = 0;
  int failures = 0;
  logic [1:0]    gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [PW-1:0] m_pos = '0;
  logic [PW-1:0] f_pos = '0;
  logic [1:0]    prev_ab = 2'b00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [PW-1:0] pos, input bit bsy, input bit dn);
    check({tag, "_ab"},    {quad_a, quad_b}, gray[pos[1:0]]);
    check({tag, "_pos"},   position, pos);
    check({tag, "_busy"},  busy, bsy);
    check({tag, "_done"},  done, dn);
    check({tag, "_ready"}, cmd_ready, !bsy);
    if ({quad_a, quad_b} !== prev_ab)
      check({tag, "_onebit"}, $countones({quad_a, quad_b} ^ prev_ab), 1);
    prev_ab = {quad_a, quad_b};
  endtask

  // Called #1 after an edge with the DUT idle. abort_at = edge offset (from the
  // handshake edge) at which abort is sampled; 0 means run to completion.
  task automatic run_cmd(input bit dir, input int n, input int abort_at);
    int np, last, cnt, jj;
    logic [PW-1:0] exp_pos;
    np   = n * P;
    last = (abort_at > 0) ? abort_at : np + 1;
    check("hs_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_dir = dir; cmd_steps = n[SW-1:0];
    @(posedge CLK); #1;
    cmd_dir = 1'($urandom); cmd_steps = SW'($urandom);
    for (int j = 0; j <= last; j++) begin
      jj  = (abort_at > 0 && j >= abort_at) ? abort_at - 1 : j;
      cnt = (jj == 0) ? 0 : (((jj - 1) / P + 1) < n ? ((jj - 1) / P + 1) : n);
      exp_pos = dir ? m_pos + PW'(cnt) : m_pos - PW'(cnt);
      check_outputs("run", exp_pos,
                    (abort_at > 0) ? (j < abort_at) : (j < np + 1),
                    (abort_at == 0) && (j == np + 1));
      if (j == last) m_pos = exp_pos;
      else begin
        cmd_valid = 1'($urandom);
        abort = (abort_at > 0 && j == abort_at - 1);
        @(posedge CLK); #1;
        abort = 1'b0;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic idle_gap(input int g);
    repeat (g) begin
      abort = 1'($urandom); cmd_dir = 1'($urandom); cmd_steps = SW'($urandom);
      @(posedge CLK); #1;
      check_outputs("idle", m_pos, 0, 0);
    end
    abort = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    #2 RST = 1'b1;
    #1;
    m_pos = '0; f_pos = '0; prev_ab = 2'b00;
    check({tag, "_ab"},    {quad_a, quad_b}, 2'b00);
    check({tag, "_pos"},   position, 0);
    check({tag, "_ready"}, cmd_ready, 1);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic fast_cmd(input bit dir, input int n);
    int e;
    f_valid = 1'b1; f_dir = dir; f_steps = n[SW-1:0];
    @(posedge CLK); #1;
    f_valid = 1'b0;
    e = 0;
    while (!f_done && e < n + 5) begin
      @(posedge CLK); #1;
      e++;
    end
    f_pos = dir ? f_pos + PW'(n) : f_pos - PW'(n);
    check("fast_done_lat", e, n + 1);
    check("fast_pos", f_position, f_pos);
    check("fast_ab", {f_a, f_b}, gray[f_pos[1:0]]);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check_outputs("reset", '0, 0, 0);
    RST = 1'b0;
    idle_gap(2);

    run_cmd(1'b1, 4, 0);
    async_reset("rst_between");
    run_cmd(1'b0, 3, 0);
    check("left3_pos", position, 16'hFFFD);
    run_cmd(1'b0, 0, 0);
    run_cmd(1'b1, 8, P + 2);
    run_cmd(1'b1, 2, 0);
    run_cmd(1'b1, 3, 0);
    idle_gap(1);

    for (int i = 0; i < 20; i++) begin
      int n, ab;
      n  = $urandom_range(0, 12);
      ab = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n * P) : 0;
      run_cmd(1'($urandom), n, ab);
      idle_gap($urandom_range(0, 2));
    end

    for (int i = 0; i < 128; i++) fast_cmd(1'b1, 255);
    fast_cmd(1'b1, 127);
    check("fast_pos_7fff", f_position, 16'h7FFF);
    fast_cmd(1'b1, 1);
    check("fast_pos_8000", f_position, 16'h8000);

    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 8'd10;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    repeat (6) @(posedge CLK);
    check("mid_busy", busy, 1);
    async_reset("rst_mid");
    #1;
    check_outputs("post_rst", '0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
